fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_skid_buf.sv | 41 ++++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared types and constants for the instruction fetch stage:
//                FSM state encoding, default reset PC and the opcode values
//                recognised by the downstream control decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,   // free to issue a request
    ST_WAIT  = 2'd1,   // one request outstanding
    ST_FULL  = 2'd2    // response parked in the skid buffer
  } fetchState_t;

  localparam logic [63:0] c_RESET_PC = 64'h0;

  // Major opcodes seen on id_opcode
  localparam logic [6:0] c_OPC_LD    = 7'b0000011;
  localparam logic [6:0] c_OPC_SD    = 7'b0100011;
  localparam logic [6:0] c_OPC_BEQ   = 7'b1100011;
  localparam logic [6:0] c_OPC_RTYPE = 7'b0110011;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : One-entry holding register for a fetch response that
//                arrived while the IF/ID register was occupied and stalled.
//                Entry payload is {pc, instr}. Flush wins over push.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf #(
  parameter int WIDTH = 96
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Single entry: flush (drain or redirect) empties it, push captures a response
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage. Issues one instruction-memory
//                request at a time, delivers {pc, instr} into the IF/ID
//                register, absorbs one response under stall via a skid
//                buffer and honours branch redirects with top priority.
//                Optional macro FETCH_PERF_EN adds fetched/bubble counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_RESET_PC)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [6:0]      id_opcode
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles
`endif
);

  fetchState_t     r_state, w_stateNext;
  logic            r_kill, w_killNext;
  logic [XLEN-1:0] r_pc, w_pcNext;
  logic [XLEN-1:0] r_reqPc, w_reqPcNext;
  logic            r_idValid, w_idValidNext;
  logic [XLEN-1:0] r_idPc, w_idPcNext;
  logic [31:0]     r_idInstr, w_idInstrNext;
  logic            w_reqValid;
  logic            w_loadId;
  logic            w_skidPush, w_skidFlush, w_skidValid;
  logic [XLEN+31:0] w_skidData;

  fetch_skid_buf #(.WIDTH(XLEN + 32)) u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_skidPush),
    .i_flush (w_skidFlush),
    .i_data  ({r_reqPc, imem_resp_data}),
    .o_valid (w_skidValid),
    .o_data  (w_skidData)
  );

  // Next-state and IF/ID update; redirect overrides every other event
  always_comb begin
    w_stateNext   = r_state;
    w_killNext    = r_kill;
    w_pcNext      = r_pc;
    w_reqPcNext   = r_reqPc;
    w_idValidNext = r_idValid & stall;   // a consumed entry drops unless refilled
    w_idPcNext    = r_idPc;
    w_idInstrNext = r_idInstr;
    w_reqValid    = 1'b0;
    w_loadId      = 1'b0;
    w_skidPush    = 1'b0;
    w_skidFlush   = 1'b0;
    if (branch_taken) begin
      w_pcNext      = branch_target;
      w_idValidNext = 1'b0;
      w_skidFlush   = 1'b1;
      if (r_state == ST_WAIT) begin
        // A response landing now belongs to the wrong path and is dropped here;
        // otherwise remember to drop it when it shows up.
        if (imem_resp_valid) begin
          w_killNext  = 1'b0;
          w_stateNext = ST_FETCH;
        end else begin
          w_killNext  = 1'b1;
        end
      end else begin
        w_stateNext = ST_FETCH;
      end
    end else begin
      case (r_state)
        ST_FETCH: begin
          w_reqValid = 1'b1;
          if (imem_req_ready) begin
            w_reqPcNext = r_pc;
            w_pcNext    = r_pc + XLEN'(4);
            w_stateNext = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            if (r_kill) begin
              w_killNext  = 1'b0;
              w_stateNext = ST_FETCH;
            end else if (!r_idValid || !stall) begin
              w_loadId      = 1'b1;
              w_idValidNext = 1'b1;
              w_idPcNext    = r_reqPc;
              w_idInstrNext = imem_resp_data;
              w_stateNext   = ST_FETCH;
            end else begin
              w_skidPush  = 1'b1;
              w_stateNext = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (!stall) begin
            w_loadId      = w_skidValid;
            w_idValidNext = w_skidValid;
            w_idPcNext    = w_skidData[XLEN+31:32];
            w_idInstrNext = w_skidData[31:0];
            w_skidFlush   = 1'b1;
            w_stateNext   = ST_FETCH;
          end
        end
        default: w_stateNext = ST_FETCH;
      endcase
    end
  end

  // State, PC and IF/ID registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= ST_FETCH;
      r_kill    <= 1'b0;
      r_pc      <= RESET_PC;
      r_reqPc   <= '0;
      r_idValid <= 1'b0;
      r_idPc    <= '0;
      r_idInstr <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_kill    <= w_killNext;
      r_pc      <= w_pcNext;
      r_reqPc   <= w_reqPcNext;
      r_idValid <= w_idValidNext;
      r_idPc    <= w_idPcNext;
      r_idInstr <= w_idInstrNext;
    end
  end

  assign imem_req_valid = w_reqValid;
  assign imem_addr      = r_pc;
  assign id_valid       = r_idValid;
  assign id_pc          = r_idPc;
  assign id_instr       = r_idInstr;
  assign id_opcode      = r_idInstr[6:0];

`ifdef FETCH_PERF_EN
  logic [31:0] r_perfFetched, r_perfBubbles;

  // Entries delivered to decode and idle decode cycles, both free-running
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_perfFetched <= '0;
      r_perfBubbles <= '0;
    end else begin
      if (w_loadId)
        r_perfFetched <= r_perfFetched + 32'd1;
      if (!r_idValid && !stall)
        r_perfBubbles <= r_perfBubbles + 32'd1;
    end
  end

  assign perf_fetched = r_perfFetched;
  assign perf_bubbles = r_perfBubbles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Randomised bench for fetch_stage with a transaction-level
//                reference model (in-flight request, skid queue, IF/ID entry)
//                and a single-outstanding instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          NCYC     = 900;

  logic        clock = 1'b0;
  logic        reset_n, stall, branch_taken;
  logic [63:0] branch_target;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  always #5 clock = ~clock;

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_instr        (id_instr),
    .id_opcode       (id_opcode)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_bubbles    (perf_bubbles)
`endif
  );

  int vectorCount    = 0;
  int miscompareCount = 0;

  task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Deterministic memory contents: opcode cycles through the decoder's set
  function automatic logic [31:0] memWord(input logic [63:0] addr);
    logic [6:0] opc;
    case (addr[3:2])
      2'd0:    opc = 7'b0000011;
      2'd1:    opc = 7'b0100011;
      2'd2:    opc = 7'b1100011;
      default: opc = 7'b0110011;
    endcase
    return {addr[31:7] ^ 25'h0ABCDEF, opc};
  endfunction

  function automatic bit chance(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  // Reference model
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [63:0] mPc;
  bit          inflight, doomed;
  logic [63:0] inflightPc;
  entry_t      skidQ[$];
  bit          idValid;
  entry_t      idEntry;
  int unsigned mFetched, mBubbles;
  bit          loaded, expReqValid, accepted;
  entry_t      e;

  // Memory model
  bit          memPending;
  int          memDelay;
  logic [31:0] memData;

  int stallPct, brPct, readyPct, maxDelay;

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    mPc = RESET_PC; inflight = 0; doomed = 0; inflightPc = '0;
    idValid = 0; idEntry = '{pc: 64'h0, instr: 32'h0};
    mFetched = 0; mBubbles = 0; memPending = 0; memDelay = 0; memData = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);
      // Stimulus profile by phase: clean streaming, heavy stall, mixed, starvation
      if (cyc < 40)        begin stallPct = 0;  brPct = 0; readyPct = 100; maxDelay = 0; end
      else if (cyc < 140)  begin stallPct = 60; brPct = 0; readyPct = 100; maxDelay = 1; end
      else if (cyc < 320)  begin stallPct = 30; brPct = 8; readyPct = 70;  maxDelay = 2; end
      else if (cyc < 380)  begin stallPct = 20; brPct = 3; readyPct = 10;  maxDelay = 1; end
      else                 begin stallPct = 35; brPct = 6; readyPct = 80;  maxDelay = 2; end

      reset_n      = !(cyc < 2 || cyc == 500);
      stall        = chance(stallPct);
      branch_taken = chance(brPct);
      if (chance(50))
        branch_target = {32'h0, ($urandom_range(4095, 0) & 32'hFFC)};
      else
        branch_target = {$urandom(), ($urandom() & 32'hFFFF_FFFC)};
      if (cyc == 200) begin branch_taken = 1'b1; branch_target = 64'h100; end
      if (cyc == 260 || cyc == 420) begin
        branch_taken  = 1'b1;
        branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
      end

      imem_resp_valid = memPending && (memDelay == 0);
      imem_resp_data  = imem_resp_valid ? memData : $urandom();
      imem_req_ready  = !memPending && chance(readyPct);

      expReqValid = !branch_taken && !inflight && (skidQ.size() == 0);
      #1;
      if (cyc > 0) begin
        checkValue("imem_req_valid", {63'h0, imem_req_valid}, {63'h0, expReqValid});
        if (expReqValid)
          checkValue("imem_addr", imem_addr, mPc);
      end

      // Memory: one response per accepted request, after 0..maxDelay idle cycles
      accepted = reset_n && expReqValid && imem_req_ready;
      if (imem_resp_valid)
        memPending = 0;
      else if (memPending && memDelay > 0)
        memDelay--;
      if (accepted) begin
        memPending = 1;
        memDelay   = $urandom_range(maxDelay, 0);
        memData    = memWord(mPc);
      end

      // Model update for this edge
      if (!reset_n) begin
        mPc = RESET_PC; inflight = 0; doomed = 0; skidQ.delete();
        idValid = 0; idEntry = '{pc: 64'h0, instr: 32'h0};
        mFetched = 0; mBubbles = 0;
      end else begin
        loaded = 0;
        if (!idValid && !stall) mBubbles++;
        if (branch_taken) begin
          mPc = branch_target;
          idValid = 0;
          skidQ.delete();
          if (inflight) begin
            if (imem_resp_valid) begin inflight = 0; doomed = 0; end
            else doomed = 1;
          end
        end else begin
          if (accepted) begin
            inflight = 1; doomed = 0; inflightPc = mPc; mPc = mPc + 64'd4;
          end else if (inflight && imem_resp_valid) begin
            inflight = 0;
            if (!doomed) begin
              e = '{pc: inflightPc, instr: imem_resp_data};
              if (!idValid || !stall) begin idEntry = e; loaded = 1; end
              else skidQ.push_back(e);
            end
            doomed = 0;
          end else if (skidQ.size() != 0 && !stall) begin
            idEntry = skidQ.pop_front();
            loaded  = 1;
          end
          if (loaded) begin idValid = 1; mFetched++; end
          else if (!stall) idValid = 0;
        end
      end

      @(posedge clock);
      #1;
      checkValue("id_valid",  {63'h0, id_valid},  {63'h0, idValid});
      checkValue("id_pc",     id_pc,              idEntry.pc);
      checkValue("id_instr",  {32'h0, id_instr},  {32'h0, idEntry.instr});
      checkValue("id_opcode", {57'h0, id_opcode}, {57'h0, idEntry.instr[6:0]});
`ifdef FETCH_PERF_EN
      checkValue("perf_fetched", {32'h0, perf_fetched}, {32'h0, mFetched});
      checkValue("perf_bubbles", {32'h0, perf_bubbles}, {32'h0, mBubbles});
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
`default_nettype wire
